lfsr_word_packer: RTL and testbench



---
 rtl/lfsr_word_packer.sv | 68 ++++++
 tb/tb_lfsr_word_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_word_packer.sv
// lfsr_word_packer: assembles the serial random-bit stream into words and
// buffers them in a show-ahead FIFO with valid/ready output and drop counting.
module lfsr_word_packer #(
  parameter int WORD_BITS     = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int DROP_CNT_BITS = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_randomBit,
  input  logic                          i_bitValid,
  output logic [WORD_BITS-1:0]          o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic [DROP_CNT_BITS-1:0]      o_dropCount
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(WORD_BITS);
  // only the bits that survive into the next word are stored
  logic [WORD_BITS-2:0]     sr_q, sr_d;
  logic [BW-1:0]            bc_q, bc_d;
  logic [PW-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [DROP_CNT_BITS-1:0] drop_q, drop_d;
  logic [WORD_BITS-1:0]     mem_q [FIFO_DEPTH];
  logic [WORD_BITS-1:0]     mem_d [FIFO_DEPTH];
  logic [WORD_BITS-1:0]     word;
  logic                     done, pop, push;
  assign o_data      = mem_q[rd_q];
  assign o_valid     = cnt_q != '0;
  assign o_count     = cnt_q;
  assign o_dropCount = drop_q;
  always_comb begin
    word   = {sr_q, i_randomBit};
    done   = i_bitValid && bc_q == BW'(WORD_BITS - 1);
    pop    = o_valid && i_ready;
    push   = done && (cnt_q != CW'(FIFO_DEPTH) || pop);
    sr_d   = i_bitValid ? word[WORD_BITS-2:0] : sr_q;
    bc_d   = done ? '0 : bc_q + BW'(i_bitValid);
    rd_d   = rd_q + PW'(pop);
    wr_d   = wr_q + PW'(push);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    drop_d = drop_q + DROP_CNT_BITS'(done && !push && !(&drop_q));
    mem_d  = mem_q;
    mem_d[wr_q] = push ? word : mem_q[wr_q];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q   <= '0;
      bc_q   <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      sr_q   <= sr_d;
      bc_q   <= bc_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      mem_q  <= mem_d;
    end
  end
endmodule

// File: tb/tb_lfsr_word_packer.sv
// tb_lfsr_word_packer: directed and random scenarios against a queue-based model;
// a second instance with a 2-bit drop counter shares the stimulus.
module tb_lfsr_word_packer;
  logic       i_clk = 1'b0;
  logic       i_rst, i_randomBit, i_bitValid, i_ready;
  logic [7:0] o_data, o_data_s, o_dropCount;
  logic       o_valid, o_valid_s;
  logic [2:0] o_count, o_count_s;
  logic [1:0] o_dropCount_s;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] q[$];
  int         acc = 0, nb = 0, drops = 0;

  lfsr_word_packer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_randomBit(i_randomBit), .i_bitValid(i_bitValid),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
    .o_dropCount(o_dropCount));
  lfsr_word_packer #(.DROP_CNT_BITS(2)) dut_s (
    .i_clk(i_clk), .i_rst(i_rst), .i_randomBit(i_randomBit), .i_bitValid(i_bitValid),
    .o_data(o_data_s), .o_valid(o_valid_s), .i_ready(i_ready), .o_count(o_count_s),
    .o_dropCount(o_dropCount_s));

  always #5 i_clk = ~i_clk;

  function automatic logic [33:0] expv();
    logic       v = q.size() != 0;
    logic [7:0] d = v ? q[0] : 8'h0;
    return {v, 3'(q.size()), d, drops > 255 ? 8'hFF : 8'(drops),
            v, 3'(q.size()), d, drops > 3 ? 2'd3 : 2'(drops)};
  endfunction

  function automatic logic [33:0] obsv();
    return {o_valid, o_count, o_valid ? o_data : 8'h0, o_dropCount,
            o_valid_s, o_count_s, o_valid_s ? o_data_s : 8'h0, o_dropCount_s};
  endfunction

  // drive one cycle and advance the model by the same edge
  task automatic step(input logic r, input logic bv, input logic b, input logic rd);
    i_rst = r; i_bitValid = bv; i_randomBit = b; i_ready = rd;
    @(posedge i_clk);
    if (r) begin
      q.delete(); acc = 0; nb = 0; drops = 0;
    end else begin
      if (q.size() != 0 && rd) void'(q.pop_front());
      if (bv) begin
        acc = acc * 2 + int'(b);
        nb++;
        if (nb == 8) begin
          if (q.size() < 4) q.push_back(8'(acc)); else drops++;
          acc = 0; nb = 0;
        end
      end
    end
    #1;
  endtask

  task automatic feed_word(input logic [7:0] w, input logic rd, input logic rd_last, input string nm);
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, 1'b1, w[i], i == 0 ? rd_last : rd);
      n_chk++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL %s bit%0d: got %h expected %h", nm, i, obsv(), expv());
      end
    end
  endtask

  task automatic drain(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                       input logic [7:0] e3, input string nm);
    logic [7:0] ex [4] = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (o_valid !== 1'b1 || o_data !== ex[i]) begin
        n_fail++;
        $display("FAIL %s pop%0d: got valid=%b data=%h expected valid=1 data=%h", nm, i, o_valid, o_data, ex[i]);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    n_chk++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL %s empty: got valid=%b count=%0d expected 0 0", nm, o_valid, o_count);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      n_chk++;
      if ({o_valid, o_count, o_dropCount, o_data, o_dropCount_s} !== 22'h0) begin
        n_fail++;
        $display("FAIL reset: got valid=%b count=%0d drop=%0d data=%h expected all 0", o_valid, o_count, o_dropCount, o_data);
      end
    end
  endtask

  task automatic test_bit_order();
    feed_word(8'hB2, 1'b1, 1'b1, "bit_order");
    n_chk++;
    if (o_valid !== 1'b1 || o_data !== 8'hB2 || o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL bit_order word: got valid=%b data=%h count=%0d expected 1 b2 1", o_valid, o_data, o_count);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (o_count !== 3'd0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bit_order pop: got count=%0d valid=%b expected 0 0", o_count, o_valid);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] w = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      step(1'b0, 1'b1, w[i], 1'b0);
      n_chk++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL gapped bit%0d: got %h expected %h", i, obsv(), expv());
      end
    end
    n_chk++;
    if (o_valid !== 1'b1 || o_data !== 8'hB2 || o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL gapped word: got valid=%b data=%h count=%0d expected 1 b2 1", o_valid, o_data, o_count);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) feed_word(8'(i), 1'b0, 1'b0, "overflow");
    n_chk++;
    if (o_count !== 3'd4 || o_dropCount !== 8'd1) begin
      n_fail++;
      $display("FAIL overflow full: got count=%0d drop=%0d expected 4 1", o_count, o_dropCount);
    end
    drain(8'h01, 8'h02, 8'h03, 8'h04, "overflow");
  endtask

  task automatic test_full_pop();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) feed_word(8'(i), 1'b0, 1'b0, "full_pop");
    feed_word(8'hAA, 1'b0, 1'b1, "full_pop");
    n_chk++;
    if (o_count !== 3'd4 || o_dropCount !== 8'd0 || o_data !== 8'h02) begin
      n_fail++;
      $display("FAIL full_pop: got count=%0d drop=%0d data=%h expected 4 0 02", o_count, o_dropCount, o_data);
    end
    drain(8'h02, 8'h03, 8'h04, 8'hAA, "full_pop");
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    feed_word(8'hFF, 1'b0, 1'b0, "reset_mid");
    n_chk++;
    if (o_valid !== 1'b1 || o_data !== 8'hFF || o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b data=%h count=%0d expected 1 ff 1", o_valid, o_data, o_count);
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) feed_word(8'($urandom), 1'b0, 1'b0, "saturation");
    n_chk++;
    if (o_dropCount_s !== 2'd3 || o_dropCount !== 8'd5 || o_count !== 3'd4) begin
      n_fail++;
      $display("FAIL saturation: got drop_s=%0d drop=%0d count=%0d expected 3 5 4", o_dropCount_s, o_dropCount, o_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom));
      n_chk++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h expected %h", i, obsv(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_gapped();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
